// File: rtl/yamin_stb_pkg.sv
// Shared types for the store-buffer drain scheduler: slot index type, drain FSM
// states and one-hot/index conversion helpers.
package yamin_stb_pkg;

  localparam int STB_SLOTS = 4;
  localparam int STB_IDX_W = 2;

  typedef logic [STB_IDX_W-1:0] stb_slot_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DCU_REQ = 2'd1,
    BIU_REQ = 2'd2,
    RETIRE  = 2'd3
  } stb_drain_state_t;

  function automatic stb_slot_idx_t onehot_to_idx(input logic [STB_SLOTS-1:0] oh);
    stb_slot_idx_t idx;
    idx = 2'd0;
    for (int i = 0; i < STB_SLOTS; i++) begin
      idx = idx | (oh[i] ? stb_slot_idx_t'(i) : 2'd0);
    end
    return idx;
  endfunction

  function automatic logic [STB_SLOTS-1:0] idx_to_onehot(input stb_slot_idx_t idx);
    logic [STB_SLOTS-1:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/yamin_stb_drain_ctrl_if.sv
// Slot-status and DCU/BIU drain handshake bundle between STB storage and the
// drain scheduler; the scheduler uses the slave view.
interface yamin_stb_drain_ctrl_if;
  import yamin_stb_pkg::*;

  logic [STB_SLOTS-1:0] slot_alloc_i;
  logic [STB_SLOTS-1:0] slot_ch_i;
  logic [STB_SLOTS-1:0] slot_closed_i;
  logic                 drain_all_i;
  logic                 dcu_ack_i;
  logic                 dcu_retry_i;
  logic                 biu_ack_i;
  logic                 dcu_req_o;
  logic                 biu_req_o;
  stb_slot_idx_t        req_slot_o;
  logic [STB_SLOTS-1:0] slot_free_o;
  logic                 drained_o;
  logic                 watchcat_o;

  modport master (
    output slot_alloc_i, slot_ch_i, slot_closed_i, drain_all_i,
           dcu_ack_i, dcu_retry_i, biu_ack_i,
    input  dcu_req_o, biu_req_o, req_slot_o, slot_free_o, drained_o, watchcat_o
  );

  modport slave (
    input  slot_alloc_i, slot_ch_i, slot_closed_i, drain_all_i,
           dcu_ack_i, dcu_retry_i, biu_ack_i,
    output dcu_req_o, biu_req_o, req_slot_o, slot_free_o, drained_o, watchcat_o
  );

endinterface

// File: rtl/yamin_stb_age_q.sv
// Allocation-order FIFO of slot indices; head is the oldest allocated slot.
// A push while full is dropped unless the same cycle also pops.
module yamin_stb_age_q
  import yamin_stb_pkg::*;
(
  input  logic          clk,
  input  logic          csysreset,
  input  logic          push_i,
  input  stb_slot_idx_t push_idx_i,
  input  logic          pop_i,
  output stb_slot_idx_t head_o,
  output logic          empty_o
);

  stb_slot_idx_t mem_q [STB_SLOTS];
  stb_slot_idx_t mem_d [STB_SLOTS];
  stb_slot_idx_t wr_ptr_q, wr_ptr_d;
  stb_slot_idx_t rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (count_q == 3'd0);
  assign full_s    = (count_q == 3'd4);
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_s || pop_ok_s);
  assign head_o    = mem_q[rd_ptr_q];

  // Pointer, storage and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_idx_i;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (csysreset) begin
      for (int i = 0; i < STB_SLOTS; i++) begin
        mem_q[i] <= 2'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/yamin_stb_drain_ctrl_sva.sv
// Protocol checker for the drain scheduler; instantiated alongside the design.
// Counts deliberate pushes into a full queue so they can be observed.
module yamin_stb_drain_ctrl_sva (
  input  logic       clk,
  input  logic       rst,
  input  logic       dcu_req_i,
  input  logic       biu_req_i,
  input  logic [3:0] slot_free_i,
  input  logic [3:0] slot_alloc_i,
  input  logic [2:0] q_count_i,
  input  logic       pop_i,
  input  logic       in_dcu_req_i,
  input  logic       dcu_ack_i,
  input  logic       dcu_retry_i,
  input  logic       ovf_expected_i,
  output logic [7:0] ovf_events_o
);

  logic overflow_s;
  assign overflow_s = (|slot_alloc_i) && (q_count_i == 3'd4) && !pop_i;

  a_req_excl: assert property (@(posedge clk) disable iff (rst) !(dcu_req_i && biu_req_i))
    else $error("dcu_req and biu_req both set");
  a_free_oh: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_free_i))
    else $error("slot_free not onehot0");
  a_alloc_oh: assert property (@(posedge clk) disable iff (rst) $onehot0(slot_alloc_i))
    else $error("slot_alloc not onehot0");
  a_push_full: assert property (@(posedge clk) disable iff (rst) !overflow_s || ovf_expected_i)
    else $error("alloc while order queue full");
  a_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop_i && (q_count_i == 3'd0)))
    else $error("pop from empty order queue");
  a_ack_retry: assert property (@(posedge clk) disable iff (rst) !(in_dcu_req_i && dcu_ack_i && dcu_retry_i))
    else $warning("dcu ack and retry together, ack taken");

  // Overflow event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_events_o <= 8'd0;
    end else if (overflow_s) begin
      ovf_events_o <= ovf_events_o + 8'd1;
    end else begin
      ovf_events_o <= ovf_events_o;
    end
  end

endmodule

// File: rtl/yamin_stb_drain_ctrl.sv
// Store-buffer drain scheduler: drains the oldest eligible slot to DCU
// (cacheable) or BIU (non-cacheable), one request at a time, with a watchcat.
module yamin_stb_drain_ctrl
  import yamin_stb_pkg::*;
#(
  parameter int NUM_SLOTS  = STB_SLOTS,
  parameter int WCAT_W     = 4,
  parameter int WCAT_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    csysreset,
  yamin_stb_drain_ctrl_if.slave   stb
);

  stb_drain_state_t     state_q, state_d;
  stb_slot_idx_t        req_slot_q, req_slot_d;
  logic                 dcu_req_q, dcu_req_d;
  logic                 biu_req_q, biu_req_d;
  logic [NUM_SLOTS-1:0] slot_free_q, slot_free_d;
  logic [WCAT_W-1:0]    wcat_cnt_q, wcat_cnt_d;
  logic                 drain_all_q, drain_all_d;

  logic          push_s;
  stb_slot_idx_t push_idx_s;
  logic          pop_s;
  stb_slot_idx_t head_s;
  logic          q_empty_s;
  logic          watchcat_s;
  logic          eligible_s;
  logic          idle_s;

  assign push_s     = |stb.slot_alloc_i;
  assign push_idx_s = onehot_to_idx(stb.slot_alloc_i);
  assign pop_s      = (state_q == RETIRE);
  assign idle_s     = (state_q == IDLE);
  assign watchcat_s = (wcat_cnt_q == WCAT_W'(WCAT_LIMIT));
  assign eligible_s = !q_empty_s && (stb.slot_closed_i[head_s] || drain_all_q || watchcat_s);

  yamin_stb_age_q u_age_q (
    .clk        (clk),
    .csysreset  (csysreset),
    .push_i     (push_s),
    .push_idx_i (push_idx_s),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .empty_o    (q_empty_s)
  );

  // Drain FSM next state; request/free outputs are derived from the next state
  // so they are flop outputs.
  always_comb begin
    state_d     = state_q;
    req_slot_d  = req_slot_q;
    slot_free_d = '0;
    case (state_q)
      IDLE: begin
        if (eligible_s) begin
          state_d    = stb.slot_ch_i[head_s] ? DCU_REQ : BIU_REQ;
          req_slot_d = head_s;
        end else begin
          state_d = IDLE;
        end
      end
      DCU_REQ: begin
        if (stb.dcu_ack_i) begin
          state_d     = RETIRE;
          slot_free_d = idx_to_onehot(req_slot_q);
        end else if (stb.dcu_retry_i) begin
          state_d = IDLE;
        end else begin
          state_d = DCU_REQ;
        end
      end
      BIU_REQ: begin
        if (stb.biu_ack_i) begin
          state_d     = RETIRE;
          slot_free_d = idx_to_onehot(req_slot_q);
        end else begin
          state_d = BIU_REQ;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dcu_req_d = (state_d == DCU_REQ);
    biu_req_d = (state_d == BIU_REQ);
  end

  // Watchcat counts only while an ineligible head waits in IDLE.
  always_comb begin
    wcat_cnt_d = wcat_cnt_q;
    if (pop_s || q_empty_s) begin
      wcat_cnt_d = '0;
    end else if (idle_s && !eligible_s && !watchcat_s) begin
      wcat_cnt_d = wcat_cnt_q + WCAT_W'(1);
    end else begin
      wcat_cnt_d = wcat_cnt_q;
    end
    drain_all_d = stb.drain_all_i || (drain_all_q && !(q_empty_s && idle_s));
  end

  always_ff @(posedge clk) begin
    if (csysreset) begin
      state_q     <= IDLE;
      req_slot_q  <= 2'd0;
      dcu_req_q   <= 1'b0;
      biu_req_q   <= 1'b0;
      slot_free_q <= '0;
      wcat_cnt_q  <= '0;
      drain_all_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_slot_q  <= req_slot_d;
      dcu_req_q   <= dcu_req_d;
      biu_req_q   <= biu_req_d;
      slot_free_q <= slot_free_d;
      wcat_cnt_q  <= wcat_cnt_d;
      drain_all_q <= drain_all_d;
    end
  end

  assign stb.dcu_req_o   = dcu_req_q;
  assign stb.biu_req_o   = biu_req_q;
  assign stb.req_slot_o  = req_slot_q;
  assign stb.slot_free_o = slot_free_q;
  assign stb.drained_o   = q_empty_s && idle_s;
  assign stb.watchcat_o  = watchcat_s;

endmodule

// File: tb/tb_yamin_stb_drain_ctrl.sv
// Scoreboard bench for yamin_stb_drain_ctrl: expected requests and frees are
// queued with the stimulus and compared as the DUT issues them.
module tb_yamin_stb_drain_ctrl;
  import yamin_stb_pkg::*;

  logic clk = 1'b0;
  logic csysreset;
  always #5 clk = ~clk;

  yamin_stb_drain_ctrl_if sif ();

  yamin_stb_drain_ctrl dut (
    .clk       (clk),
    .csysreset (csysreset),
    .stb       (sif)
  );

  logic       ovf_expected;
  logic [7:0] ovf_events;

  yamin_stb_drain_ctrl_sva u_sva (
    .clk            (clk),
    .rst            (csysreset),
    .dcu_req_i      (sif.dcu_req_o),
    .biu_req_i      (sif.biu_req_o),
    .slot_free_i    (sif.slot_free_o),
    .slot_alloc_i   (sif.slot_alloc_i),
    .q_count_i      (dut.u_age_q.count_q),
    .pop_i          (dut.pop_s),
    .in_dcu_req_i   (dut.state_q == DCU_REQ),
    .dcu_ack_i      (sif.dcu_ack_i),
    .dcu_retry_i    (sif.dcu_retry_i),
    .ovf_expected_i (ovf_expected),
    .ovf_events_o   (ovf_events)
  );

  typedef struct packed {
    logic          to_dcu;
    stb_slot_idx_t slot;
  } req_t;

  req_t       exp_req_q[$];
  logic [3:0] exp_free_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         retries_left = 0;
  logic       biu_auto     = 1'b1;
  logic       biu_force    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_req(input logic is_dcu);
    req_t got;
    req_t want;
    got = {is_dcu, sif.req_slot_o};
    chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
    if (exp_req_q.size() != 0) begin
      want = exp_req_q.pop_front();
      chk("req_route_slot", 32'(got), 32'(want));
    end
  endtask

  task automatic sb_free();
    logic [3:0] want;
    chk("free_expected", 32'(exp_free_q.size() != 0), 32'd1);
    if (exp_free_q.size() != 0) begin
      want = exp_free_q.pop_front();
      chk("slot_free", 32'(sif.slot_free_o), 32'(want));
    end
  endtask

  // Monitor plus DCU/BIU responder, both on the falling edge.
  initial begin : mon
    logic prev_dcu;
    logic prev_biu;
    prev_dcu        = 1'b0;
    prev_biu        = 1'b0;
    sif.dcu_ack_i   = 1'b0;
    sif.dcu_retry_i = 1'b0;
    sif.biu_ack_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (!csysreset) begin
        if (sif.dcu_req_o && !prev_dcu) sb_req(1'b1);
        if (sif.biu_req_o && !prev_biu) sb_req(1'b0);
        if (sif.slot_free_o != 4'b0000) sb_free();
      end
      prev_dcu = sif.dcu_req_o;
      prev_biu = sif.biu_req_o;
      if (sif.dcu_req_o && !sif.dcu_ack_i && !sif.dcu_retry_i) begin
        if (retries_left > 0) begin
          sif.dcu_retry_i = 1'b1;
          retries_left--;
        end else begin
          sif.dcu_ack_i = 1'b1;
        end
      end else begin
        sif.dcu_ack_i   = 1'b0;
        sif.dcu_retry_i = 1'b0;
      end
      if (biu_auto) sif.biu_ack_i = sif.biu_req_o && !sif.biu_ack_i;
      else          sif.biu_ack_i = biu_force;
    end
  end

  task automatic alloc(input int s, input logic ch);
    sif.slot_ch_i[s] = ch;
    sif.slot_alloc_i = 4'b0001 << s;
    @(negedge clk);
    sif.slot_alloc_i = 4'b0000;
  endtask

  task automatic expect_drain(input logic to_dcu, input int s);
    exp_req_q.push_back({to_dcu, 2'(s)});
    exp_free_q.push_back(4'b0001 << s);
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (!(sif.drained_o && exp_req_q.size() == 0 && exp_free_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(sif.drained_o), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_req_q.size() + exp_free_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    csysreset         = 1'b1;
    ovf_expected      = 1'b0;
    sif.slot_alloc_i  = 4'b0000;
    sif.slot_ch_i     = 4'b0000;
    sif.slot_closed_i = 4'b0000;
    sif.drain_all_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dcu_req", 32'(sif.dcu_req_o), 32'd0);
    chk("rst_biu_req", 32'(sif.biu_req_o), 32'd0);
    chk("rst_slot_free", 32'(sif.slot_free_o), 32'd0);
    chk("rst_drained", 32'(sif.drained_o), 32'd1);
    chk("rst_watchcat", 32'(sif.watchcat_o), 32'd0);
    chk("rst_req_slot", 32'(sif.req_slot_o), 32'd0);
    csysreset = 1'b0;
    @(negedge clk);

    // 1: ordered drain, routing by cacheable attribute
    alloc(2, 1'b1);
    chk("t1_drained_after_push", 32'(sif.drained_o), 32'd0);
    alloc(0, 1'b0);
    alloc(3, 1'b1);
    expect_drain(1'b1, 2);
    expect_drain(1'b0, 0);
    expect_drain(1'b1, 3);
    sif.slot_closed_i = 4'b1111;
    wait_drained("t1");
    sif.slot_closed_i = 4'b0000;

    // 2: DCU retry twice, then accepted
    retries_left      = 2;
    sif.slot_closed_i = 4'b0010;
    exp_req_q.push_back({1'b1, 2'd1});
    exp_req_q.push_back({1'b1, 2'd1});
    alloc(1, 1'b1);
    expect_drain(1'b1, 1);
    wait_drained("t2");
    chk("t2_retries_used", 32'(retries_left), 32'd0);
    sif.slot_closed_i = 4'b0000;

    // 3: watchcat forces an open head after 8 idle cycles
    alloc(0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t3_watchcat_c%0d", k), 32'(sif.watchcat_o), 32'(k == 8));
      chk($sformatf("t3_no_req_c%0d", k), 32'(sif.dcu_req_o), 32'd0);
    end
    expect_drain(1'b1, 0);
    @(negedge clk);
    chk("t3_req_after_wcat", 32'(sif.dcu_req_o), 32'd1);
    chk("t3_wcat_held", 32'(sif.watchcat_o), 32'd1);
    wait_drained("t3");
    chk("t3_wcat_cleared", 32'(sif.watchcat_o), 32'd0);

    // 4: full queue, dropped alloc, alloc coincident with retire
    alloc(0, 1'b1);
    alloc(1, 1'b1);
    alloc(2, 1'b1);
    alloc(3, 1'b1);
    chk("t4_count_full", 32'(dut.u_age_q.count_q), 32'd4);
    ovf_expected = 1'b1;
    alloc(1, 1'b1);
    ovf_expected = 1'b0;
    chk("t4_count_after_ovf", 32'(dut.u_age_q.count_q), 32'd4);
    chk("t4_ovf_seen", 32'(ovf_events), 32'd1);
    expect_drain(1'b1, 0);
    sif.slot_closed_i = 4'b0001;
    n = 0;
    while (sif.slot_free_o == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_retire_seen", 32'(sif.slot_free_o != 4'b0000), 32'd1);
    sif.slot_closed_i = 4'b0000;
    alloc(0, 1'b1);
    chk("t4_count_push_pop", 32'(dut.u_age_q.count_q), 32'd4);
    expect_drain(1'b1, 1);
    expect_drain(1'b1, 2);
    expect_drain(1'b1, 3);
    expect_drain(1'b1, 0);
    sif.slot_closed_i = 4'b1111;
    wait_drained("t4");
    sif.slot_closed_i = 4'b0000;

    // 5: drain_all pulse drains open slots, latch then clears
    alloc(0, 1'b1);
    alloc(1, 1'b0);
    alloc(2, 1'b1);
    expect_drain(1'b1, 0);
    expect_drain(1'b0, 1);
    expect_drain(1'b1, 2);
    sif.drain_all_i = 1'b1;
    @(negedge clk);
    sif.drain_all_i = 1'b0;
    wait_drained("t5");
    @(negedge clk);
    chk("t5_latch_clear", 32'(dut.drain_all_q), 32'd0);
    alloc(3, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_open_slot_waits", 32'(sif.dcu_req_o | sif.biu_req_o), 32'd0);
    expect_drain(1'b1, 3);
    sif.slot_closed_i = 4'b1000;
    wait_drained("t5b");

    // 6: reset during BIU request drops it; late ack ignored
    biu_auto = 1'b0;
    exp_req_q.push_back({1'b0, 2'd3});
    alloc(3, 1'b0);
    n = 0;
    while (!sif.biu_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_biu_req", 32'(sif.biu_req_o), 32'd1);
    csysreset = 1'b1;
    @(negedge clk);
    csysreset = 1'b0;
    chk("t6_rst_biu_req", 32'(sif.biu_req_o), 32'd0);
    chk("t6_rst_dcu_req", 32'(sif.dcu_req_o), 32'd0);
    chk("t6_rst_free", 32'(sif.slot_free_o), 32'd0);
    chk("t6_rst_watchcat", 32'(sif.watchcat_o), 32'd0);
    chk("t6_rst_drained", 32'(sif.drained_o), 32'd1);
    sif.slot_closed_i = 4'b0000;
    biu_force = 1'b1;
    repeat (2) @(negedge clk);
    biu_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_late_ack_free", 32'(sif.slot_free_o), 32'd0);
      chk("t6_late_ack_req", 32'(sif.biu_req_o | sif.dcu_req_o), 32'd0);
      chk("t6_late_ack_drained", 32'(sif.drained_o), 32'd1);
    end
    biu_auto = 1'b1;
    chk("final_sb_empty", 32'(exp_req_q.size() + exp_free_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
